// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared SCCB types and constants
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_NA,
        ST_IGNORE
    } sccb_state_e;

    // Bit index of the don't-care / acknowledge bit within a 9-bit phase
    localparam int DC_BIT = 8;

    localparam logic [7:0] SCCB_DEV_ID = 8'h60;

endpackage

// File: rtl/sccb_slave_if.sv
// rtl/sccb_slave_if.sv - SCCB clock input and register-commit outputs
interface sccb_slave_if;
    logic       sio_c;
    logic       reg_we;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       busy;

    modport master (
        output sio_c,
        input  reg_we, reg_addr, reg_wdata, busy
    );

    modport slave (
        input  sio_c,
        output reg_we, reg_addr, reg_wdata, busy
    );
endinterface

// File: rtl/sccb_regfile.sv
// rtl/sccb_regfile.sv - 256x8 register bank, sync write, comb read
module sccb_regfile
    import sccb_pkg::*;
(
    input  logic       XCLK,
    input  logic       RST,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem_q [256];

    always_ff @(posedge XCLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sccb_slave.sv
// rtl/sccb_slave.sv - SCCB responder: sync, decode, register bank, open-drain SIO_D
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = SCCB_DEV_ID,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        XCLK,
    input  logic        RST,
    inout  wire         SIO_D,
    sccb_slave_if.slave bus
);

    localparam logic [3:0] LAST_BIT = 4'(DC_BIT - 1);
    localparam logic [3:0] DC_CNT   = 4'(DC_BIT);

    // Idle bus level is high, so the synchronizers reset high to avoid phantom edges
    logic [SYNC_STAGES-1:0] c_sync_q, d_sync_q;
    logic                   c_prev_q, d_prev_q;
    logic                   c_s, d_s;
    logic                   c_rise, c_fall, start_det, stop_det;

    always_ff @(posedge XCLK or negedge RST) begin
        if (!RST) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            c_prev_q <= 1'b1;
            d_prev_q <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], bus.sio_c};
            d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], SIO_D};
            c_prev_q <= c_s;
            d_prev_q <= d_s;
        end
    end

    assign c_s       = c_sync_q[SYNC_STAGES-1];
    assign d_s       = d_sync_q[SYNC_STAGES-1];
    assign c_rise    =  c_s & ~c_prev_q;
    assign c_fall    = ~c_s &  c_prev_q;
    assign start_det =  c_s &  c_prev_q &  d_prev_q & ~d_s;
    assign stop_det  =  c_s &  c_prev_q & ~d_prev_q &  d_s;

    sccb_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  sub_addr_q, sub_addr_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        reg_we_q, reg_we_d;
    logic        busy_q, busy_d;
    logic        oe_q, oe_d;
    logic        rd_q, rd_d;
    logic [7:0]  byte_in;
    logic        last_bit;
    logic [7:0]  rf_rdata;

    always_ff @(posedge XCLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            sub_addr_q  <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            oe_q        <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            sub_addr_q  <= sub_addr_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            oe_q        <= oe_d;
            rd_q        <= rd_d;
        end
    end

    assign byte_in  = {shift_q[6:0], d_s};
    assign last_bit = c_rise && (cnt_q == LAST_BIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        sub_addr_d  = sub_addr_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        busy_d      = busy_q;
        oe_d        = oe_q;
        rd_d        = rd_q;

        if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            shift_d = 8'h00;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ST_ID;
            cnt_d   = 4'd0;
            shift_d = 8'h00;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                ST_ID: begin
                    if (c_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                    end
                    if (last_bit) begin
                        if (byte_in[7:1] == DEV_ID[7:1]) begin
                            state_d = ST_ID_ACK;
                            rd_d    = byte_in[0];
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_SUB: begin
                    if (c_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                    end
                    if (last_bit) begin
                        sub_addr_d = byte_in;
                        state_d    = ST_SUB_ACK;
                    end
                end
                ST_WDATA: begin
                    if (c_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                    end
                    if (last_bit) begin
                        reg_we_d    = 1'b1;
                        reg_addr_d  = sub_addr_q;
                        reg_wdata_d = byte_in;
                        state_d     = ST_WDATA_ACK;
                    end
                end
                // First fall asserts the acknowledge, the following fall ends the DC bit
                ST_ID_ACK: begin
                    if (c_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            cnt_d = 4'd0;
                            if (rd_q) begin
                                shift_d = rf_rdata;
                                oe_d    = ~rf_rdata[7];
                                state_d = ST_RDATA;
                            end else begin
                                oe_d    = 1'b0;
                                state_d = ST_SUB;
                            end
                        end
                    end
                end
                ST_SUB_ACK: begin
                    if (c_fall) begin
                        oe_d = ~oe_q;
                        if (oe_q) begin
                            cnt_d   = 4'd0;
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_WDATA_ACK: begin
                    if (c_fall) begin
                        oe_d = ~oe_q;
                        if (oe_q) begin
                            cnt_d   = 4'd0;
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_RDATA: begin
                    if (c_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (c_fall && cnt_q != 4'd0) begin
                        if (cnt_q == DC_CNT) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = ST_RDATA_NA;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                ST_RDATA_NA: begin
                    if (c_rise) begin
                        state_d = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    sccb_regfile u_regfile (
        .XCLK  (XCLK),
        .RST   (RST),
        .we    (reg_we_d),
        .waddr (sub_addr_q),
        .wdata (byte_in),
        .raddr (sub_addr_q),
        .rdata (rf_rdata)
    );

    // Gating with RST releases the line without waiting for the flop to clear
    assign SIO_D         = (oe_q && RST) ? 1'b0 : 1'bz;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// tb/tb_sccb_slave.sv - directed SCCB master bench for sccb_slave
module tb_sccb_slave;

    logic xclk = 1'b0;
    logic rst  = 1'b0;
    logic m_low = 1'b0;
    wire  sio_d;

    int vectors     = 0;
    int miscompares = 0;
    int we_pulses   = 0;
    int we_cycles   = 0;
    logic we_prev   = 1'b0;

    sccb_slave_if bus_if ();

    pullup (sio_d);
    assign sio_d = m_low ? 1'b0 : 1'bz;

    sccb_slave #(.DEV_ID(8'h60), .SYNC_STAGES(2)) dut (
        .XCLK  (xclk),
        .RST   (rst),
        .SIO_D (sio_d),
        .bus   (bus_if)
    );

    always #5 xclk = ~xclk;

    always @(negedge xclk) begin
        if (bus_if.reg_we && !we_prev) we_pulses++;
        if (bus_if.reg_we) we_cycles++;
        we_prev = bus_if.reg_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_q();
        repeat (10) @(posedge xclk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic seen);
        wait_q();
        m_low = ~b;
        wait_q();
        bus_if.sio_c = 1'b1;
        wait_q();
        seen = sio_d;
        wait_q();
        bus_if.sio_c = 1'b0;
    endtask

    task automatic do_start();
        m_low = 1'b0;
        wait_q();
        bus_if.sio_c = 1'b1;
        wait_q();
        m_low = 1'b1;
        wait_q();
        bus_if.sio_c = 1'b0;
    endtask

    task automatic do_stop();
        wait_q();
        m_low = 1'b1;
        wait_q();
        bus_if.sio_c = 1'b1;
        wait_q();
        m_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] b, output logic na);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(1'b1, na);
    endtask

    task automatic read_reg(input logic [7:0] addr, output logic [7:0] val);
        logic a0, a1, a2, na;
        do_start();
        write_byte(8'h60, a0);
        write_byte(addr, a1);
        do_stop();
        do_start();
        write_byte(8'h61, a2);
        read_byte(val, na);
        do_stop();
        check("rdreg_acks", {a0, a1, a2}, 3'b000);
    endtask

    initial begin
        logic       a0, a1, a2, na, s;
        logic [7:0] rd;

        bus_if.sio_c = 1'b1;
        repeat (4) @(posedge xclk);
        #1;
        check("rst_sio_d", sio_d, 1'b1);
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_reg_we", bus_if.reg_we, 1'b0);
        check("rst_reg_addr", bus_if.reg_addr, 8'h00);
        check("rst_reg_wdata", bus_if.reg_wdata, 8'h00);
        rst = 1'b1;
        wait_q();

        // 3-phase write 0x80 -> reg 0x12
        do_start();
        check("w3_busy_hi", bus_if.busy, 1'b1);
        write_byte(8'h60, a0);
        write_byte(8'h12, a1);
        write_byte(8'h80, a2);
        check("w3_acks", {a0, a1, a2}, 3'b000);
        check("w3_pulses", we_pulses, 1);
        check("w3_reg_addr", bus_if.reg_addr, 8'h12);
        check("w3_reg_wdata", bus_if.reg_wdata, 8'h80);
        do_stop();
        check("w3_busy_lo", bus_if.busy, 1'b0);
        check("w3_we_width", we_cycles, 1);

        // 2-phase write then 2-phase read
        do_start();
        write_byte(8'h60, a0);
        write_byte(8'h12, a1);
        do_stop();
        do_start();
        write_byte(8'h61, a2);
        read_byte(rd, na);
        do_stop();
        check("r2_acks", {a0, a1, a2}, 3'b000);
        check("r2_data", rd, 8'h80);
        check("r2_na_released", na, 1'b1);
        check("r2_no_we", we_pulses, 1);

        // Wrong device ID
        do_start();
        write_byte(8'h42, a0);
        write_byte(8'h12, a1);
        write_byte(8'h55, a2);
        do_stop();
        check("wid_acks", {a0, a1, a2}, 3'b111);
        check("wid_no_we", we_pulses, 1);
        read_reg(8'h42, rd);
        check("wid_reg42", rd, 8'h00);

        // STOP mid data byte
        do_start();
        write_byte(8'h60, a0);
        write_byte(8'h20, a1);
        write_byte(8'hA5, a2);
        do_stop();
        check("mid_setup_pulses", we_pulses, 2);
        do_start();
        write_byte(8'h60, a0);
        write_byte(8'h20, a1);
        for (int i = 7; i >= 4; i--) send_bit(logic'(i[0]), s);
        do_stop();
        check("mid_no_we", we_pulses, 2);
        read_reg(8'h20, rd);
        check("mid_reg20", rd, 8'hA5);

        // Repeated START into a read
        do_start();
        write_byte(8'h60, a0);
        write_byte(8'h12, a1);
        do_start();
        write_byte(8'h61, a2);
        read_byte(rd, na);
        do_stop();
        check("rs_acks", {a0, a1, a2}, 3'b000);
        check("rs_data", rd, 8'h80);
        check("rs_we_width", we_cycles, 2);

        // Reset while the slave drives a 0 data bit (reg 0x12 = 1000_0000)
        do_start();
        write_byte(8'h61, a0);
        check("rr_ack", a0, 1'b0);
        send_bit(1'b1, s);
        check("rr_bit7", s, 1'b1);
        wait_q();
        check("rr_driving0", sio_d, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rr_sio_d_rel", sio_d, 1'b1);
        check("rr_busy", bus_if.busy, 1'b0);
        check("rr_reg_addr", bus_if.reg_addr, 8'h00);
        check("rr_reg_wdata", bus_if.reg_wdata, 8'h00);
        check("rr_reg_we", bus_if.reg_we, 1'b0);
        @(posedge xclk);
        #1;
        rst = 1'b1;
        bus_if.sio_c = 1'b1;
        wait_q();
        wait_q();
        read_reg(8'h12, rd);
        check("rr_reg12_cleared", rd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sccb_slave.md
# sccb_slave

SCCB 2-wire responder: the target end of the camera control bus driven by our SCCB master. It oversamples SIO_C/SIO_D on XCLK, decodes the 3-phase write and the 2-phase write / 2-phase read transactions, holds a 256x8 register file and drives SIO_D open-drain for DC (acknowledge) bits and read data. It acts as the camera-side model in verification and as the bus target for any on-chip SCCB register bank.

## Interface
- DEV_ID, 8'h60, write ID; the read ID is DEV_ID | 1; only bits [7:1] are compared.
- SYNC_STAGES, 2, synchronizer depth on SIO_C and SIO_D (minimum 2).
- XCLK  in  1  system clock, 50 MHz.
- RST  in  1  asynchronous, active-low reset.
- SIO_C  in  1  SCCB clock from the master.
- SIO_D  inout  1  SCCB data; this block drives only 0 or Z.
- reg_we  out  1  one-XCLK pulse when a register write commits.
- reg_addr  out  8  sub-address of the last committed write.
- reg_wdata  out  8  data of the last committed write.
- busy  out  1  high from START to STOP.

## Operation
- **Synchronization and edge detection.**
  - SIO_C and SIO_D each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized signals.
  - START: SIO_D falls while SIO_C is high. STOP: SIO_D rises while SIO_C is high.
- **Bit timing.**
  - Bits are sampled on the synchronized SIO_C rising edge, MSB first.
  - Drive changes happen only on the synchronized SIO_C falling edge.
  - A 4-bit counter counts 0..8; count 8 is the DC bit.
- **States.**
  - IDLE to ID on START.
  - ID: shift in 8 bits, then compare.
    - ID[7:1] matches and ID[0]=0: ID_ACK, then SUB.
    - ID[7:1] matches and ID[0]=1: ID_ACK, then RDATA.
    - ID[7:1] does not match: IGNORE.
  - SUB: shift in 8 bits, latch sub_addr, then SUB_ACK, then WDATA.
  - WDATA: shift in 8 bits, then WDATA_ACK, then IGNORE.
    - The write commits on the SIO_C rise that samples the 8th bit.
    - On commit: regfile[sub_addr] is written, reg_we pulses, and reg_addr/reg_wdata update.
  - RDATA: regfile[sub_addr] is loaded into the shift register at the end of ID_ACK.
    - The 8 bits are driven on SIO_C falling edges: a 0 bit drives 0, a 1 bit releases to Z.
    - Then RDATA_NA: SIO_D released, the master's bit is ignored, then IGNORE.
  - ACK states: SIO_D is driven to 0 from the falling edge after the 8th bit until the next falling edge.
  - IGNORE: SIO_D released; waits for START or STOP.
- **STOP in any state** goes to IDLE: SIO_D released, busy=0, shift and counter cleared.
  - sub_addr is retained, so a 2-phase write followed by a 2-phase read reads that address.
- **START in any state** (repeated start) goes to ID with the counter cleared.
- **Aborted transactions.** A partially received data byte never commits. Additional bytes after the data byte are ignored; there is no auto-increment.
- **Simultaneous events.** STOP/START detection has priority over bit sampling in the same XCLK.

## Timing
- **Reset values.** SIO_D=Z, reg_we=0, reg_addr=0, reg_wdata=0, busy=0, sub_addr=0, all registers 8'h00, state IDLE.
- **Reset mid-operation.** SIO_D is released asynchronously, in the same cycle RST falls.
- **Edge-detect latency.** SYNC_STAGES+1 XCLK cycles from a pad edge.
- **SIO_D output latency.** The SIO_D output changes at most SYNC_STAGES+2 XCLK after the SIO_C pad fall, well inside the 5 us low half-period.
- **Clock ratio.** XCLK is at least 20x the SIO_C frequency; at nominal rates it is 500x.
- **reg_we.** Exactly one XCLK wide. reg_addr/reg_wdata update in the same cycle and hold until the next commit.
- **busy.** Rises one cycle after START is detected and falls one cycle after STOP is detected.

## Structure
- **Package sccb_pkg** holds:
  - the state enum;
  - the DC bit index constant (8);
  - the default DEV_ID (8'h60), shared with the master.
- **Sub-module sccb_regfile**: 256x8, one synchronous write port and one combinational read port, reset to 0. The top holds the FSM, synchronizers, shifter and drive logic.

## Test plan
- **3-phase write.** START, 0x60, 0x12, 0x80, STOP -> SIO_D=0 on all three DC bits; one reg_we pulse with reg_addr=0x12, reg_wdata=0x80; busy returns to 0.
- **2-phase write then 2-phase read.** 2-phase write 0x60, 0x12 then STOP; 2-phase read 0x61, master NA, STOP -> slave drives 1000_0000 MSB first and releases SIO_D on the NA bit; no reg_we.
- **Wrong ID.** START, 0x42, 0x12, 0x55, STOP -> SIO_D stays Z throughout; no reg_we; register 0x42 unchanged.
- **STOP mid-byte.** STOP after 4 data bits of a write to 0x20 -> no reg_we; register 0x20 keeps its old value; next transaction is decoded normally.
- **Repeated start.** START, 0x60, 0x12, repeated START, 0x61, read -> returns regfile[0x12]; ID decoding restarts cleanly.
- **Reset mid-read.** Assert RST while the slave drives a 0 bit -> SIO_D goes Z immediately; all outputs take reset values; registers cleared.
